pc_fetch_unit: RTL and testbench

//   Fetch/sequencing registers for the multicycle MIPS core, directly downstream of the main decoder.

---
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 tb/tb_pc_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Purpose: PC, IR, MDR and ALUOut registers for the multicycle MIPS core, plus fetch/branch counters.
// Latency: Adr is combinational; every register updates on the posedge after its enables are sampled.
// Backpressure: none; the decoder drives enables every cycle and this block always accepts them.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic [1:0]       PCSource,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic             Zero,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      ReadData,
  output logic [31:0]      Adr,
  output logic [31:0]      PC,
  output logic [31:0]      Instr,
  output logic [31:0]      Data,
  output logic [31:0]      ALUOut,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic             misalign
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      aluout_q, aluout_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic             misalign_q, misalign_d;

  logic [31:0]      pc_next;
  logic             pc_en;
  logic             src_valid;
  logic             aligned;
  logic             br_taken;

  // Next-PC candidate; source 11 is reserved and simply re-selects the current PC.
  always_comb begin
    pc_next = pc_q;
    unique case (PCSource)
      2'b00:   pc_next = ALUResult;
      2'b01:   pc_next = aluout_q;
      2'b10:   pc_next = {pc_q[31:28], instr_q[25:0], 2'b00};
      default: pc_next = pc_q;
    endcase
  end

  // Next-state for all registers: guarded PC update, sticky misalign, IR/MDR/ALUOut and counters.
  always_comb begin
    pc_en       = PCWrite | (Branch & Zero);
    src_valid   = (PCSource != 2'b11);
    aligned     = (pc_next[1:0] == 2'b00);
    br_taken    = Branch & Zero & src_valid & aligned;

    pc_d        = pc_q;
    misalign_d  = misalign_q;
    instr_d     = instr_q;
    data_d      = ReadData;
    aluout_d    = ALUResult;
    fetch_cnt_d = fetch_cnt_q;
    br_cnt_d    = br_cnt_q;

    // A misaligned target is dropped rather than loaded; the flag only ever sets.
    if (pc_en && src_valid) begin
      if (aligned) begin
        pc_d = pc_next;
      end else begin
        misalign_d = 1'b1;
      end
    end

    if (IRWrite) begin
      instr_d     = ReadData;
      fetch_cnt_d = fetch_cnt_q + CNT_ONE;
    end

    if (br_taken) begin
      br_cnt_d = br_cnt_q + CNT_ONE;
    end
  end

  // State registers; reset is asynchronous so PC snaps to RESET_PC without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      data_q      <= '0;
      aluout_q    <= '0;
      fetch_cnt_q <= '0;
      br_cnt_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      data_q      <= data_d;
      aluout_q    <= aluout_d;
      fetch_cnt_q <= fetch_cnt_d;
      br_cnt_q    <= br_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  assign Adr          = IorD ? aluout_q : pc_q;
  assign PC           = pc_q;
  assign Instr        = instr_q;
  assign Data         = data_q;
  assign ALUOut       = aluout_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign br_taken_cnt = br_cnt_q;
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose: self-checking bench for pc_fetch_unit (directed scenarios then randomized cycles).
// Latency: checks registered outputs on the negedge after each posedge, Adr #1 after driving inputs.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_pc_fetch_unit;

  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             pc_write, branch, iord, ir_write, zero;
  logic [1:0]       pc_source;
  logic [31:0]      alu_result, read_data;
  logic [31:0]      adr, pc, instr, data, aluout;
  logic [CNT_W-1:0] fetch_cnt, br_taken_cnt;
  logic             misalign;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, updated from the architectural rules once per rising edge.
  logic [31:0]      m_pc, m_ir, m_mdr, m_aluout;
  logic [CNT_W-1:0] m_fc, m_bc;
  logic             m_mis;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .PCWrite      (pc_write),
    .Branch       (branch),
    .PCSource     (pc_source),
    .IorD         (iord),
    .IRWrite      (ir_write),
    .Zero         (zero),
    .ALUResult    (alu_result),
    .ReadData     (read_data),
    .Adr          (adr),
    .PC           (pc),
    .Instr        (instr),
    .Data         (data),
    .ALUOut       (aluout),
    .fetch_cnt    (fetch_cnt),
    .br_taken_cnt (br_taken_cnt),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ir = '0; m_mdr = '0; m_aluout = '0;
    m_fc = '0; m_bc = '0; m_mis = 1'b0;
  endtask

  // One clock of the reference: every value computed from the pre-edge state and inputs.
  task automatic model_step();
    logic [31:0] target;
    logic        want_pc, usable;
    want_pc = pc_write || (branch && zero);
    if (pc_source == 2'd0)      target = alu_result;
    else if (pc_source == 2'd1) target = m_aluout;
    else if (pc_source == 2'd2) target = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
    else                        target = m_pc;
    usable = (pc_source != 2'd3) && (target % 4 == 0);
    if (branch && zero && usable) m_bc = m_bc + 1'b1;
    if (ir_write) begin
      m_ir = read_data;
      m_fc = m_fc + 1'b1;
    end
    if (want_pc && pc_source != 2'd3) begin
      if (usable) m_pc = target;
      else        m_mis = 1'b1;
    end
    m_mdr    = read_data;
    m_aluout = alu_result;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".pc"},    pc,     m_pc);
    check_val({tag, ".instr"}, instr,  m_ir);
    check_val({tag, ".data"},  data,   m_mdr);
    check_val({tag, ".alu"},   aluout, m_aluout);
    check_val({tag, ".fcnt"},  32'(fetch_cnt),    32'(m_fc));
    check_val({tag, ".bcnt"},  32'(br_taken_cnt), 32'(m_bc));
    check_val({tag, ".mis"},   32'(misalign),     32'(m_mis));
  endtask

  task automatic drive(input logic pw, input logic br, input logic [1:0] src, input logic io,
                       input logic irw, input logic z, input logic [31:0] alu, input logic [31:0] rd);
    pc_write = pw; branch = br; pc_source = src; iord = io;
    ir_write = irw; zero = z; alu_result = alu; read_data = rd;
    #1;
    check_val("adr", adr, io ? m_aluout : m_pc);
  endtask

  // Clock one edge, advance the model alongside it, then check on the following negedge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    pc_write = 0; branch = 0; pc_source = 0; iord = 0; ir_write = 0; zero = 0;
    alu_result = '0; read_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_all("init");

    // Move PC to 0x40, then pull reset mid-cycle and expect an immediate clear.
    drive(1, 0, 2'd0, 0, 1, 0, 32'h40, 32'h1234_5678);
    cycle("pre_rst");
    check_val("pc_40", pc, 32'h40);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_pc",   pc, RESET_PC);
    check_val("rst_ir",   instr, 32'h0);
    check_val("rst_fcnt", 32'(fetch_cnt), 32'h0);
    check_val("rst_mis",  32'(misalign), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Fetch: PC+4 and IR load in the same edge; IR takes the word at the old PC.
    drive(1, 0, 2'd0, 0, 1, 0, 32'h4, 32'h8C01_0004);
    check_val("fetch_adr", adr, 32'h0);
    cycle("fetch");
    check_val("fetch_pc", pc, 32'h4);
    check_val("fetch_ir", instr, 32'h8C01_0004);
    check_val("fetch_cnt1", 32'(fetch_cnt), 32'd1);

    // Branch taken via ALUOut, then the same branch with Zero low.
    drive(0, 0, 2'd0, 1, 0, 0, 32'h20, 32'h0);
    cycle("ld_aluout");
    drive(0, 1, 2'd1, 1, 0, 1, 32'h30, 32'h0);
    check_val("br_adr", adr, 32'h20);
    cycle("br_taken");
    check_val("br_pc", pc, 32'h20);
    check_val("br_cnt1", 32'(br_taken_cnt), 32'd1);
    drive(0, 1, 2'd1, 0, 0, 0, 32'h50, 32'h0);
    cycle("br_not");
    check_val("brn_pc", pc, 32'h20);
    check_val("brn_cnt", 32'(br_taken_cnt), 32'd1);

    // Jump target formed from PC upper nibble and IR[25:0], then reserved source holds.
    drive(1, 0, 2'd0, 0, 1, 0, 32'hA000_0008, 32'h0800_0010);
    cycle("ld_jump");
    drive(1, 0, 2'd2, 0, 0, 0, 32'h0, 32'h0);
    cycle("jump");
    check_val("jump_pc", pc, 32'hA000_0040);
    drive(1, 0, 2'd3, 0, 0, 0, 32'h100, 32'h0);
    cycle("hold11");
    check_val("hold_pc", pc, 32'hA000_0040);
    drive(0, 1, 2'd3, 0, 0, 1, 32'h100, 32'h0);
    cycle("br11");
    check_val("br11_cnt", 32'(br_taken_cnt), 32'd1);

    // Misaligned write is rejected and sticks; a later aligned write still lands.
    drive(1, 0, 2'd0, 0, 0, 0, 32'h6, 32'h0);
    cycle("mis");
    check_val("mis_pc", pc, 32'hA000_0040);
    check_val("mis_flag", 32'(misalign), 32'd1);
    drive(1, 0, 2'd0, 0, 0, 0, 32'h8, 32'h0);
    cycle("mis_ok");
    check_val("mis_pc8", pc, 32'h8);
    check_val("mis_stick", 32'(misalign), 32'd1);

    // Fetch counter wrap at 2^CNT_W.
    for (int i = 0; i < 32 && m_fc != '1; i++) begin
      drive(0, 0, 2'd0, 0, 1, 0, 32'h0, $urandom);
      cycle("fill");
    end
    check_val("fcnt_max", 32'(fetch_cnt), 32'((1 << CNT_W) - 1));
    drive(0, 0, 2'd0, 0, 1, 0, 32'h0, 32'hDEAD_BEEF);
    cycle("wrap");
    check_val("fcnt_wrap", 32'(fetch_cnt), 32'h0);

    // Random traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] alu;
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            alu, $urandom);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
